// File: rtl/adc_sequencer.sv
// Sequencer and capture stage for the bit-serial SAR ADC, with round-robin channel scan.
// Define ADC_SEQ_AVG_EN to average 2**AVG_LOG2 conversions per output.
module adc_sequencer #(
    parameter int unsigned CONV_CYCLES = 10
`ifdef ADC_SEQ_AVG_EN
    ,
    parameter int unsigned AVG_LOG2 = 2
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [1:0]              chan_mask,
    output logic                    adc_restart,
    output logic                    adc_channel,
    input  logic [9:0]              adc_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [9:0]              out_data,
    output logic                    out_chan,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic                    busy
);
    localparam int unsigned DATA_W = 10;
    localparam int unsigned CNT_W  = $clog2(CONV_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    wait_cnt, wait_cnt_next;
    logic                chan_next;
    logic                complete_c;
    logic [DATA_W-1:0]   result_c;

`ifdef ADC_SEQ_AVG_EN
    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;

    logic [AVG_LOG2-1:0] samp_cnt, samp_cnt_next;
    logic [ACC_W-1:0]    acc, acc_next, acc_sum_c;
`endif

    // Next-state, channel selection and result path
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        chan_next     = adc_channel;
        complete_c    = 1'b0;
        result_c      = adc_result;
`ifdef ADC_SEQ_AVG_EN
        samp_cnt_next = samp_cnt;
        acc_next      = acc;
        acc_sum_c     = acc + ACC_W'(adc_result);
`endif
        case (state)
            IDLE: begin
                if (enable && (chan_mask != 2'b00)) begin
                    chan_next  = ~chan_mask[0];
                    state_next = START;
                end
            end
            START: begin
                wait_cnt_next = CNT_W'(CONV_CYCLES);
                state_next    = WAIT;
            end
            WAIT: begin
                if (wait_cnt != '0) begin
                    wait_cnt_next = wait_cnt - CNT_W'(1);
                end else begin
`ifdef ADC_SEQ_AVG_EN
                    // Intermediate samples always continue on the same channel
                    if (samp_cnt != '1) begin
                        samp_cnt_next = samp_cnt + AVG_LOG2'(1);
                        acc_next      = acc_sum_c;
                        state_next    = START;
                    end else begin
                        samp_cnt_next = '0;
                        acc_next      = '0;
                        result_c      = acc_sum_c[ACC_W-1:AVG_LOG2];
                        complete_c    = 1'b1;
                    end
`else
                    complete_c = 1'b1;
`endif
                    if (complete_c) begin
                        if (enable && (chan_mask != 2'b00)) begin
                            chan_next  = chan_mask[~adc_channel] ? ~adc_channel : adc_channel;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            adc_restart <= 1'b0;
            adc_channel <= 1'b0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_chan    <= 1'b0;
            overrun     <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
            samp_cnt    <= '0;
            acc         <= '0;
`endif
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            adc_channel <= chan_next;
            adc_restart <= (state_next == START);
            busy        <= (state_next == START) || (state_next == WAIT);
`ifdef ADC_SEQ_AVG_EN
            samp_cnt    <= samp_cnt_next;
            acc         <= acc_next;
`endif
            if (complete_c && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_data  <= result_c;
                out_chan  <= adc_channel;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear keeps the flag set
            if (complete_c && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed self-checking bench for adc_sequencer with a per-channel constant ADC model.
module tb_adc_sequencer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [1:0] chan_mask;
    logic       adc_restart;
    logic       adc_channel;
    logic [9:0] adc_result;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_data;
    logic       out_chan;
    logic       overrun;
    logic       overrun_clr;
    logic       busy;

    logic [9:0] val0, val1;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    assign adc_result = adc_channel ? val1 : val0;

    adc_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .chan_mask   (chan_mask),
        .adc_restart (adc_restart),
        .adc_channel (adc_channel),
        .adc_result  (adc_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        enable      = 1'b0;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_restart"}, 32'(adc_restart), 32'd0);
        check({tag, "_channel"}, 32'(adc_channel), 32'd0);
        check({tag, "_valid"},   32'(out_valid),   32'd0);
        check({tag, "_data"},    32'(out_data),    32'd0);
        check({tag, "_chan"},    32'(out_chan),    32'd0);
        check({tag, "_overrun"}, 32'(overrun),     32'd0);
        check({tag, "_busy"},    32'(busy),        32'd0);
    endtask

`ifndef ADC_SEQ_AVG_EN
    logic [9:0] rr_data [3];
    logic       rr_chan [3];
`else
    logic [9:0] seq [8];
`endif

    initial begin
        chan_mask = 2'b00;
        val0 = '0;
        val1 = '0;
        do_reset();
        check_all_zero("rst");

`ifndef ADC_SEQ_AVG_EN
        // Single channel, back-to-back conversions
        chan_mask = 2'b01;
        val0 = 10'h2A5;
        out_ready = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("single_start_restart", 32'(adc_restart), 32'd1);
        check("single_start_busy",    32'(busy),        32'd1);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1)  check("single_restart_pulse", 32'(adc_restart), 32'd0);
            if (c == 11) check("single_valid_early",   32'(out_valid),   32'd0);
            if (c == 12) begin
                check("single_valid",      32'(out_valid),   32'd1);
                check("single_data",       32'(out_data),    32'h2A5);
                check("single_chan",       32'(out_chan),    32'd0);
                check("single_restart_b2b", 32'(adc_restart), 32'd1);
            end
            if (c == 13) check("single_valid_drop", 32'(out_valid), 32'd0);
        end

        // Round-robin over both channels
        do_reset();
        chan_mask = 2'b11;
        val0 = 10'h100;
        val1 = 10'h3FF;
        out_ready = 1'b1;
        enable = 1'b1;
        begin
            int  n      = 0;
            logic cur_ch = 1'b0;
            logic ch_err = 1'b0;
            for (int c = 0; c < 100 && n < 3; c++) begin
                @(negedge clk);
                if (adc_restart) cur_ch = adc_channel;
                else if (busy && adc_channel != cur_ch) ch_err = 1'b1;
                if (out_valid) begin
                    rr_data[n] = out_data;
                    rr_chan[n] = out_chan;
                    n++;
                end
            end
            check("rr_count", 32'(n), 32'd3);
            check("rr_chan_stable", 32'(ch_err), 32'd0);
        end
        check("rr0_chan", 32'(rr_chan[0]), 32'd0);
        check("rr0_data", 32'(rr_data[0]), 32'h100);
        check("rr1_chan", 32'(rr_chan[1]), 32'd1);
        check("rr1_data", 32'(rr_data[1]), 32'h3FF);
        check("rr2_chan", 32'(rr_chan[2]), 32'd0);
        check("rr2_data", 32'(rr_data[2]), 32'h100);

        // Backpressure, overrun, clear and simultaneous load/transfer
        do_reset();
        chan_mask = 2'b01;
        val0 = 10'h155;
        enable = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk);
            case (c)
                12: begin
                    check("bp_first_valid", 32'(out_valid), 32'd1);
                    check("bp_first_data",  32'(out_data),  32'h155);
                    val0 = 10'h0AA;
                end
                23: check("bp_no_overrun_yet", 32'(overrun), 32'd0);
                24: check("bp_overrun_set",    32'(overrun), 32'd1);
                29: begin
                    check("bp_hold_valid", 32'(out_valid), 32'd1);
                    check("bp_hold_data",  32'(out_data),  32'h155);
                    out_ready   = 1'b1;
                    overrun_clr = 1'b1;
                end
                30: begin
                    check("bp_xfer_valid", 32'(out_valid), 32'd0);
                    check("bp_clr_overrun", 32'(overrun),  32'd0);
                    out_ready   = 1'b0;
                    overrun_clr = 1'b0;
                end
                36: begin
                    check("bp_third_valid", 32'(out_valid), 32'd1);
                    check("bp_third_data",  32'(out_data),  32'h0AA);
                end
                40: val0 = 10'h0F0;
                47: out_ready = 1'b1;
                48: begin
                    check("sim_valid",   32'(out_valid), 32'd1);
                    check("sim_data",    32'(out_data),  32'h0F0);
                    check("sim_overrun", 32'(overrun),   32'd0);
                end
                49: check("sim_drained", 32'(out_valid), 32'd0);
                default: ;
            endcase
        end

        // Reset in the middle of a conversion
        check("midrst_busy_before", 32'(busy), 32'd1);
        do_reset();
        check_all_zero("midrst");
        repeat (15) @(negedge clk);
        check("midrst_idle_valid", 32'(out_valid), 32'd0);
        check("midrst_idle_busy",  32'(busy),      32'd0);
`else
        // Averaging of four samples on channel 0
        seq[0] = 10'd10; seq[1] = 10'd11; seq[2] = 10'd12; seq[3] = 10'd14;
        seq[4] = 10'd0;  seq[5] = 10'd0;  seq[6] = 10'd0;  seq[7] = 10'd0;
        chan_mask = 2'b01;
        out_ready = 1'b1;
        enable = 1'b1;
        begin
            int k = 0;
            for (int c = 0; c <= 49; c++) begin
                @(negedge clk);
                if (adc_restart && k < 8) begin
                    val0 = seq[k];
                    k++;
                end
                if (c == 12) check("avg_no_early_valid", 32'(out_valid), 32'd0);
                if (c == 47) check("avg_valid_early",    32'(out_valid), 32'd0);
                if (c == 48) begin
                    check("avg_valid", 32'(out_valid), 32'd1);
                    check("avg_data",  32'(out_data),  32'd11);
                    check("avg_chan",  32'(out_chan),  32'd0);
                    check("avg_restart", 32'(adc_restart), 32'd1);
                end
            end
            check("avg_starts", 32'(k), 32'd5);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
